// File: rtl/id_pkg.sv
// Shared decode-stage constants: instruction field positions, immediate modes
// and the register-selector range helper.
package id_pkg;

  localparam int unsigned REG_AW = 3;
  localparam int unsigned RS_MSB = 10;
  localparam int unsigned RS_LSB = 8;
  localparam int unsigned RT_MSB = 7;
  localparam int unsigned RT_LSB = 5;
  localparam int unsigned RD_MSB = 4;
  localparam int unsigned RD_LSB = 2;
  localparam int unsigned JMP_W  = 11;

  typedef enum logic [1:0] {
    IMM_SEXT5  = 2'd0,
    IMM_ZEXT5  = 2'd1,
    IMM_SEXT8  = 2'd2,
    IMM_SEXT11 = 2'd3
  } imm_mode_e;

  function automatic logic reg_in_range(input logic [REG_AW-1:0] sel,
                                        input int unsigned nregs);
    return 32'(sel) < nregs;
  endfunction

endpackage

// File: rtl/id_stage_pipe_regfile.sv
// Register file with synchronous clear, combinational reads and same-cycle
// write-back bypass; flags writes aimed at non-existent registers.
module regfile_bypass
  import id_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_wsel,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_ra1,
  input  logic [REG_AW-1:0] i_ra2,
  output logic [DATA_W-1:0] o_rd1_c,
  output logic [DATA_W-1:0] o_rd2_c,
  output logic              o_wr_oob_c
);

  logic [DATA_W-1:0] r_mem [NREGS];
  logic              w_wr_ok;

  assign w_wr_ok    = i_we & reg_in_range(i_wsel, NREGS);
  assign o_wr_oob_c = i_we & ~reg_in_range(i_wsel, NREGS);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (w_wr_ok) begin
      for (int i = 0; i < NREGS; i++)
        if (i_wsel == REG_AW'(i)) r_mem[i] <= i_wdata;
    end
  end

  // Out-of-range selectors read as zero; only a real write is bypassed.
  always_comb begin
    o_rd1_c = '0;
    o_rd2_c = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (i_ra1 == REG_AW'(i)) o_rd1_c = r_mem[i];
      if (i_ra2 == REG_AW'(i)) o_rd2_c = r_mem[i];
    end
    if (w_wr_ok && (i_wsel == i_ra1)) o_rd1_c = i_wdata;
    if (w_wr_ok && (i_wsel == i_ra2)) o_rd2_c = i_wdata;
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: operand read, immediate/jump formation, load-use
// hazard detection and the ID/EX pipeline register.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned NREGS   = 8,
  parameter int unsigned PC_HI_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [15:0]       instr,
  input  logic [15:0]       pc,
  input  logic              dec_reg_dst,
  input  logic              dec_is_load,
  input  logic              dec_use_rt,
  input  logic [1:0]        dec_imm_mode,
  input  logic              wb_we,
  input  logic [2:0]        wb_sel,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_stall,
  input  logic              flush,
  output logic              id_ready,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_r1,
  output logic [DATA_W-1:0] ex_r2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_jaddr,
  output logic [2:0]        ex_rd,
  output logic              ex_is_load,
  output logic              err
);

  logic [REG_AW-1:0] w_rs, w_rt;
  logic [DATA_W-1:0] w_r1, w_r2, w_imm, w_jaddr;
  logic              w_wr_oob, w_src_oob, w_hz, w_unused;

  logic              r_ex_valid, r_ex_is_load, r_err;
  logic [DATA_W-1:0] r_ex_r1, r_ex_r2, r_ex_imm, r_ex_jaddr;
  logic [2:0]        r_ex_rd;

  assign w_rs     = instr[RS_MSB:RS_LSB];
  assign w_rt     = instr[RT_MSB:RT_LSB];
  assign w_unused = ^{instr[15:JMP_W], pc};

  regfile_bypass #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
    .clk        (clk),
    .rst        (rst),
    .i_we       (wb_we),
    .i_wsel     (wb_sel),
    .i_wdata    (wb_data),
    .i_ra1      (w_rs),
    .i_ra2      (w_rt),
    .o_rd1_c    (w_r1),
    .o_rd2_c    (w_r2),
    .o_wr_oob_c (w_wr_oob)
  );

  always_comb begin
    w_imm = '0;
    case (imm_mode_e'(dec_imm_mode))
      IMM_SEXT5:  w_imm = {{(DATA_W-5){instr[4]}}, instr[4:0]};
      IMM_ZEXT5:  w_imm = {{(DATA_W-5){1'b0}}, instr[4:0]};
      IMM_SEXT8:  w_imm = {{(DATA_W-8){instr[7]}}, instr[7:0]};
      IMM_SEXT11: w_imm = {{(DATA_W-11){instr[10]}}, instr[10:0]};
    endcase
  end

  assign w_jaddr = DATA_W'({pc[15 -: PC_HI_W], instr[JMP_W-1:0]});

  // A load in EX whose destination feeds this decode forces one bubble.
  assign w_hz = r_ex_valid & r_ex_is_load & if_valid &
                ((r_ex_rd == w_rs) | (dec_use_rt & (r_ex_rd == w_rt)));

  assign w_src_oob = if_valid & (~reg_in_range(w_rs, NREGS) |
                                 (dec_use_rt & ~reg_in_range(w_rt, NREGS)));

  assign id_ready = ~rst & ~ex_stall & ~w_hz;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid   <= 1'b0;
      r_ex_r1      <= '0;
      r_ex_r2      <= '0;
      r_ex_imm     <= '0;
      r_ex_jaddr   <= '0;
      r_ex_rd      <= '0;
      r_ex_is_load <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_err <= r_err | w_wr_oob | w_src_oob;
      if (flush || (!ex_stall && w_hz)) begin
        r_ex_valid <= 1'b0;
      end else if (!ex_stall) begin
        r_ex_valid   <= if_valid;
        r_ex_r1      <= w_r1;
        r_ex_r2      <= w_r2;
        r_ex_imm     <= w_imm;
        r_ex_jaddr   <= w_jaddr;
        r_ex_rd      <= dec_reg_dst ? instr[RD_MSB:RD_LSB] : instr[RT_MSB:RT_LSB];
        r_ex_is_load <= dec_is_load;
      end
    end
  end

  assign ex_valid   = r_ex_valid;
  assign ex_r1      = r_ex_r1;
  assign ex_r2      = r_ex_r2;
  assign ex_imm     = r_ex_imm;
  assign ex_jaddr   = r_ex_jaddr;
  assign ex_rd      = r_ex_rd;
  assign ex_is_load = r_ex_is_load;
  assign err        = r_err;

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised next-generation instruction-decode stage.
- Contains the register file with write-back bypass, immediate generation with selectable extension modes, and jump-address formation.
- Adds an ID/EX pipeline register with valid/stall/flush handling and load-use hazard detection.
- Sits between fetch and execute. Write-back drives its write port.

Parameters:
- DATA_W, 16, register/immediate/jump data width (>=16).
- NREGS, 8, number of architectural registers (2..8; the ISA encodes 3-bit selectors).
- PC_HI_W, 5, number of upper PC bits concatenated into the jump address; jump address width is PC_HI_W+11 and must be <= DATA_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- if_valid  in  1  instr/pc valid from fetch
- instr  in  16  instruction; rs=[10:8], rt=[7:5], rd=[4:2]
- pc  in  16  PC of instr
- dec_reg_dst  in  1  0: dest=rt, 1: dest=rd
- dec_is_load  in  1  instr is a load
- dec_use_rt  in  1  instr reads rt as a source
- dec_imm_mode  in  2  0 sext[4:0], 1 zext[4:0], 2 sext[7:0], 3 sext[10:0]
- wb_we  in  1  register write enable
- wb_sel  in  3  write register index
- wb_data  in  DATA_W  write data
- ex_stall  in  1  execute cannot accept; hold ID/EX
- flush  in  1  kill ID/EX contents (branch taken)
- id_ready  out  1  decode accepts instr this cycle
- ex_valid  out  1  ID/EX holds a valid instruction
- ex_r1, ex_r2  out  DATA_W  source operands
- ex_imm  out  DATA_W  extended immediate
- ex_jaddr  out  DATA_W  {pc[15:16-PC_HI_W], instr[10:0]}, zero-extended to DATA_W
- ex_rd  out  3  destination index
- ex_is_load  out  1  registered dec_is_load
- err  out  1  sticky error flag

Behaviour:
- Reset (synchronous):
  - all NREGS registers = 0;
  - ex_valid=0; ex_r1/ex_r2/ex_imm/ex_jaddr=0; ex_rd=0; ex_is_load=0; err=0.
  - id_ready is combinational and equals 0 while rst=1.
- Register file:
  - Write at the clk edge when wb_we=1 and wb_sel<NREGS.
  - Reads are combinational. If wb_we=1 and wb_sel equals the read selector in the same cycle, wb_data is bypassed to the read.
- Error:
  - err is set on the clk edge when wb_we=1 and wb_sel>=NREGS; no write occurs.
  - err is also set on the clk edge when if_valid=1 and rs>=NREGS, or when if_valid=1, dec_use_rt=1 and rt>=NREGS.
  - err is cleared only by rst.
- Hazard (combinational):
  - hz = ex_valid & ex_is_load & if_valid & (ex_rd==rs | (dec_use_rt & ex_rd==rt)).
  - id_ready = ~rst & ~ex_stall & ~hz.
- ID/EX update priority each clk edge:
  - rst, then flush, then ex_stall, then hz, then normal.
  - flush: ex_valid<=0; data fields don't-care. Flush wins over ex_stall.
  - ex_stall: all ID/EX fields hold.
  - hz: bubble, ex_valid<=0; fetch must hold instr/pc (id_ready=0).
  - normal: ex_valid<=if_valid; operands, immediate, jaddr, rd and is_load are captured from the current instr.
- Latency: one cycle from accepted instr to ex_valid.
- Load-use penalty: exactly one bubble. The cycle after the bubble, hz=0 because ex_valid=0.
- Immediate formation:
  - sign extension replicates the top field bit to DATA_W;
  - zext fills with 0.
- ex_rd = dec_reg_dst ? instr[4:2] : instr[7:5].
- Write-back in the same cycle as an accepted decode: the bypassed value is captured.

Decomposition:
- Package id_pkg: imm-mode constants (IMM_SEXT5, IMM_ZEXT5, IMM_SEXT8, IMM_SEXT11), field-position localparams (RS_MSB/LSB, RT_MSB/LSB, RD_MSB/LSB, JMP_W=11), REG_AW=3.
- Sub-module regfile_bypass #(DATA_W, NREGS): storage, reset clear, bypassed reads, write-range check output. The stage instantiates it and owns hazard logic and ID/EX registers.

Test Plan:
- Reset then read: rst 2 cycles, decode rs=3, rt=5 -> ex_r1=0, ex_r2=0, ex_valid=1 one cycle after if_valid.
- Bypass: wb_we=1, wb_sel=2, wb_data=16'hBEEF in the same cycle as decode with rs=2 -> ex_r1=16'hBEEF next cycle; the following decode of rs=2 also reads 16'hBEEF.
- Immediates: instr[10:0]=11'h41F:
  - mode0 -> 16'hFFFF;
  - mode1 -> 16'h001F;
  - mode2 -> 16'h001F;
  - mode3 -> 16'hFC1F.
- Load-use: load with dec_reg_dst=0, rt=4, then instr with rs=4 -> id_ready=0 for 1 cycle, one ex_valid=0 bubble, then the dependent instr issues with id_ready=1.
- Stall vs flush: ex_stall=1 for 3 cycles holds all ex_* outputs constant; ex_stall=1 and flush=1 together -> ex_valid=0 next cycle.
- Error: with NREGS=6, wb_we=1, wb_sel=7 -> err=1 next cycle and stays 1; no register changes; rst clears err.
